// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the PC sequencer: opcodes, FSM states, PC step.
package cpu_seq_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_OFFSET,
        S_WAIT_CMP,
        S_STORE,
        S_UPDATE
    } state_t;

endpackage

// File: rtl/cpu_pc_sequencer_if.sv
// Bundle of the fetch, offset-generator, comparator and store-port signals
// around the PC sequencer. master = the sequencer, slave = its surroundings.
interface cpu_pc_sequencer_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic        branch_offset;
    logic        store_offset;
    logic        jump_offset;
    logic [31:0] offset_in;
    logic        cmp_valid;
    logic        cmp_taken;
    logic        store_req;
    logic [31:0] store_addr;
    logic        store_ack;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] link_addr;
    logic        link_we;
    logic        misalign_err;

    modport master (
        input  instr_valid, instruction, rs1_data, offset_in,
               cmp_valid, cmp_taken, store_ack,
        output instr_ready, branch_offset, store_offset, jump_offset,
               store_req, store_addr, pc, pc_valid, link_addr, link_we,
               misalign_err
    );

    modport slave (
        output instr_valid, instruction, rs1_data, offset_in,
               cmp_valid, cmp_taken, store_ack,
        input  instr_ready, branch_offset, store_offset, jump_offset,
               store_req, store_addr, pc, pc_valid, link_addr, link_we,
               misalign_err
    );

endinterface

// File: rtl/cpu_instr_class.sv
// Opcode classifier: one-hot branch/store/JAL flags, all zero for anything
// else (JALR included).
module cpu_instr_class
    import cpu_seq_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       is_branch,
    output logic       is_store,
    output logic       is_jal
);

    assign is_branch = (opcode == OP_BRANCH);
    assign is_store  = (opcode == OP_STORE);
    assign is_jal    = (opcode == OP_JAL);

endmodule

// File: rtl/cpu_pc_sequencer.sv
// Multi-cycle PC / offset-select sequencer. Accepts one instruction at a time,
// steers the offset generator, waits for the comparator or store port as
// needed, then commits the new PC (or flags a misaligned target).
module cpu_pc_sequencer
    import cpu_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_pc_sequencer_if.master    bus
);

    state_t      state, state_nxt;
    logic [31:0] instr_q, rs1_q, offset_q, target_q;
    logic [31:0] pc_q, link_q;
    logic        pc_valid_q, link_we_q, misalign_q;
    logic        sel_br_q, sel_st_q, sel_jp_q;
    logic        is_branch, is_store, is_jal;
    logic        misaligned;

    // Class is taken from the latched word so it stays stable for the whole op.
    cpu_instr_class u_class (
        .opcode    (instr_q[6:0]),
        .is_branch (is_branch),
        .is_store  (is_store),
        .is_jal    (is_jal)
    );

    assign misaligned = ALIGN_CHECK && (target_q[1:0] != 2'b00);

    assign bus.instr_ready   = (state == S_IDLE);
    assign bus.store_req     = (state == S_STORE);
    assign bus.store_addr    = (state == S_STORE) ? rs1_q + offset_q : 32'd0;
    assign bus.branch_offset = sel_br_q;
    assign bus.store_offset  = sel_st_q;
    assign bus.jump_offset   = sel_jp_q;
    assign bus.pc            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.link_addr     = link_q;
    assign bus.link_we       = link_we_q;
    assign bus.misalign_err  = misalign_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.instr_valid) state_nxt = S_DECODE;
            S_DECODE:   state_nxt = (is_branch || is_store || is_jal) ? S_OFFSET : S_UPDATE;
            S_OFFSET:   begin
                if (is_jal)         state_nxt = S_UPDATE;
                else if (is_branch) state_nxt = S_WAIT_CMP;
                else                state_nxt = S_STORE;
            end
            S_WAIT_CMP: if (bus.cmp_valid) state_nxt = S_UPDATE;
            S_STORE:    if (bus.store_ack) state_nxt = S_UPDATE;
            S_UPDATE:   state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, target computation, selects and PC commit.
    // Selects default low so each one is high only for the single S_OFFSET cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= 32'd0;
            rs1_q      <= 32'd0;
            offset_q   <= 32'd0;
            target_q   <= 32'd0;
            pc_q       <= RESET_PC;
            link_q     <= 32'd0;
            pc_valid_q <= 1'b0;
            link_we_q  <= 1'b0;
            misalign_q <= 1'b0;
            sel_br_q   <= 1'b0;
            sel_st_q   <= 1'b0;
            sel_jp_q   <= 1'b0;
        end else begin
            pc_valid_q <= 1'b0;
            link_we_q  <= 1'b0;
            sel_br_q   <= 1'b0;
            sel_st_q   <= 1'b0;
            sel_jp_q   <= 1'b0;
            case (state)
                S_IDLE: if (bus.instr_valid) begin
                    instr_q <= bus.instruction;
                    rs1_q   <= bus.rs1_data;
                end
                S_DECODE: begin
                    sel_br_q <= is_branch;
                    sel_st_q <= is_store;
                    sel_jp_q <= is_jal;
                    target_q <= pc_q + PC_INC;
                end
                S_OFFSET: begin
                    offset_q <= bus.offset_in;
                    if (is_jal) target_q <= pc_q + bus.offset_in;
                end
                S_WAIT_CMP: if (bus.cmp_valid)
                    target_q <= bus.cmp_taken ? pc_q + offset_q : pc_q + PC_INC;
                S_STORE: if (bus.store_ack)
                    target_q <= pc_q + PC_INC;
                S_UPDATE: begin
                    if (misaligned) begin
                        misalign_q <= 1'b1;
                    end else begin
                        pc_q       <= target_q;
                        pc_valid_q <= 1'b1;
                        if (is_jal) begin
                            link_q    <= pc_q + PC_INC;
                            link_we_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_pc_sequencer.sv
// Bench for cpu_pc_sequencer: table of instructions with hand-derived
// outcomes, scoreboarded through a queue, plus idle-noise and async-reset
// sequences.
module tb_cpu_pc_sequencer;

    localparam logic [31:0] I_ADD  = 32'h00B5_0533;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_BR   = 32'h0000_0063;
    localparam logic [31:0] I_ST   = 32'h0000_0023;
    localparam logic [31:0] I_JALR = 32'h0000_0067;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] off;
        int          cmp_at;   // cycle after accept at which cmp_valid is driven
        logic        taken;
        int          ack_at;   // cycle after accept at which store_ack is driven
        logic [31:0] e_pc;
        int          e_lat;
        logic        e_pcv;
        logic        e_we;
        logic [31:0] e_link;
        logic        e_mis;
        logic [2:0]  e_sel;    // {branch, store, jump}
        int          e_req;
        logic [31:0] e_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[17];
    vec_t exp_q[$];

    cpu_pc_sequencer_if bus();

    cpu_pc_sequencer #(.RESET_PC(32'h0), .ALIGN_CHECK(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [31:0] instr, logic [31:0] rs1, logic [31:0] off,
                                int cmp_at, logic taken, int ack_at,
                                logic [31:0] e_pc, int e_lat, logic e_pcv, logic e_we,
                                logic [31:0] e_link, logic e_mis, logic [2:0] e_sel,
                                int e_req, logic [31:0] e_addr);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.off = off;
        v.cmp_at = cmp_at; v.taken = taken; v.ack_at = ack_at;
        v.e_pc = e_pc; v.e_lat = e_lat; v.e_pcv = e_pcv; v.e_we = e_we;
        v.e_link = e_link; v.e_mis = e_mis; v.e_sel = e_sel;
        v.e_req = e_req; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one instruction through the DUT, acting as fetch, offset generator,
    // comparator and store port; compares against the queued expectation.
    task automatic exec(input int idx, input vec_t v);
        vec_t e;
        int c, lat, br_n, st_n, jp_n, req_n, pcv_n, we_n, addr_bad;
        logic [31:0] pc_s, link_s;
        logic mis_s;
        string t;
        t = $sformatf("v%0d", idx);
        lat = 0; br_n = 0; st_n = 0; jp_n = 0; req_n = 0; pcv_n = 0; we_n = 0; addr_bad = 0;
        pc_s = '0; link_s = '0; mis_s = 1'b0;
        c = 0;
        while (!bus.instr_ready && c < 100) begin @(negedge clk); c++; end
        bus.instruction = v.instr;
        bus.rs1_data    = v.rs1;
        bus.offset_in   = v.off;
        bus.instr_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            bus.cmp_valid = (k == v.cmp_at);
            bus.cmp_taken = v.taken;
            bus.store_ack = (k == v.ack_at);
            if (bus.branch_offset) br_n++;
            if (bus.store_offset)  st_n++;
            if (bus.jump_offset)   jp_n++;
            if (bus.store_req) begin
                req_n++;
                if (bus.store_addr !== v.e_addr) addr_bad++;
            end
            if (bus.pc_valid) pcv_n++;
            if (bus.link_we)  we_n++;
            if (bus.instr_ready) begin
                lat = k; pc_s = bus.pc; link_s = bus.link_addr; mis_s = bus.misalign_err;
                break;
            end
        end
        bus.cmp_valid = 1'b0;
        bus.store_ack = 1'b0;
        // one more cycle so over-long pulses are counted too
        @(negedge clk);
        if (bus.pc_valid) pcv_n++;
        if (bus.link_we)  we_n++;
        chk({t, " queue"}, exp_q.size(), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk({t, " latency"},     lat,    e.e_lat);
        chk({t, " pc"},          pc_s,   e.e_pc);
        chk({t, " pc_valid"},    pcv_n,  {31'd0, e.e_pcv});
        chk({t, " link_we"},     we_n,   {31'd0, e.e_we});
        chk({t, " misalign"},    mis_s,  e.e_mis);
        chk({t, " sel_branch"},  br_n,   {31'd0, e.e_sel[2]});
        chk({t, " sel_store"},   st_n,   {31'd0, e.e_sel[1]});
        chk({t, " sel_jump"},    jp_n,   {31'd0, e.e_sel[0]});
        chk({t, " store_req"},   req_n,  e.e_req);
        chk({t, " store_addr"},  addr_bad, 0);
        if (e.e_we) chk({t, " link_addr"}, link_s, e.e_link);
    endtask

    initial begin
        bus.instr_valid = 1'b0; bus.instruction = '0; bus.rs1_data = '0;
        bus.offset_in = '0; bus.cmp_valid = 1'b0; bus.cmp_taken = 1'b0; bus.store_ack = 1'b0;

        //           instr   rs1           off           cmp t ack  pc            lat pcv we link        mis sel     req addr
        vecs[0]  = mk(I_ADD,  32'h0,        32'h55,       0, 0, 0,  32'h4,        3, 1, 0, 32'h0,     0, 3'b000, 0, 32'h0);
        vecs[1]  = mk(I_JAL,  32'h0,        32'hFC,       0, 0, 0,  32'h100,      4, 1, 1, 32'h8,     0, 3'b001, 0, 32'h0);
        vecs[2]  = mk(I_JAL,  32'h0,        32'h20,       0, 0, 0,  32'h120,      4, 1, 1, 32'h104,   0, 3'b001, 0, 32'h0);
        vecs[3]  = mk(I_JAL,  32'h0,        32'hFFFFFEF0, 0, 0, 0,  32'h10,       4, 1, 1, 32'h124,   0, 3'b001, 0, 32'h0);
        vecs[4]  = mk(I_BR,   32'h0,        32'hFFFFFFF8, 5, 1, 0,  32'h8,        7, 1, 0, 32'h0,     0, 3'b100, 0, 32'h0);
        vecs[5]  = mk(I_JAL,  32'h0,        32'h8,        0, 0, 0,  32'h10,       4, 1, 1, 32'hC,     0, 3'b001, 0, 32'h0);
        vecs[6]  = mk(I_BR,   32'h0,        32'hFFFFFFF8, 5, 0, 0,  32'h14,       7, 1, 0, 32'h0,     0, 3'b100, 0, 32'h0);
        vecs[7]  = mk(I_ST,   32'h1000,     32'hC,        0, 0, 5,  32'h18,       7, 1, 0, 32'h0,     0, 3'b010, 3, 32'h100C);
        vecs[8]  = mk(I_JALR, 32'h0,        32'h40,       0, 0, 0,  32'h1C,       3, 1, 0, 32'h0,     0, 3'b000, 0, 32'h0);
        vecs[9]  = mk(I_JAL,  32'h0,        32'hFFFFFFE0, 0, 0, 0,  32'hFFFFFFFC, 4, 1, 1, 32'h20,    0, 3'b001, 0, 32'h0);
        vecs[10] = mk(I_ADD,  32'h0,        32'h0,        0, 0, 0,  32'h0,        3, 1, 0, 32'h0,     0, 3'b000, 0, 32'h0);
        vecs[11] = mk(I_ST,   32'hFFFFFFF0, 32'h20,       0, 0, 3,  32'h4,        5, 1, 0, 32'h0,     0, 3'b010, 1, 32'h10);
        vecs[12] = mk(I_BR,   32'h0,        32'h100,      3, 1, 0,  32'h104,      5, 1, 0, 32'h0,     0, 3'b100, 0, 32'h0);
        vecs[13] = mk(I_JAL,  32'h0,        32'h2,        0, 0, 0,  32'h104,      4, 0, 0, 32'h0,     1, 3'b001, 0, 32'h0);
        vecs[14] = mk(I_ADD,  32'h0,        32'h0,        0, 0, 0,  32'h108,      3, 1, 0, 32'h0,     1, 3'b000, 0, 32'h0);
        vecs[15] = mk(I_BR,   32'h0,        32'h6,        3, 1, 0,  32'h108,      5, 0, 0, 32'h0,     1, 3'b100, 0, 32'h0);
        vecs[16] = mk(I_BR,   32'h0,        32'h6,        3, 0, 0,  32'h10C,      5, 1, 0, 32'h0,     1, 3'b100, 0, 32'h0);

        // reset state
        repeat (2) @(negedge clk);
        chk("reset pc",        bus.pc,           32'h0);
        chk("reset ready",     bus.instr_ready,  1);
        chk("reset selects",   {bus.branch_offset, bus.store_offset, bus.jump_offset}, 0);
        chk("reset store_req", bus.store_req,    0);
        chk("reset pulses",    {bus.pc_valid, bus.link_we, bus.misalign_err}, 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) exec(i, vecs[i]);

        // comparator / store-port noise while idle must not disturb anything
        bus.cmp_valid = 1'b1; bus.cmp_taken = 1'b1; bus.store_ack = 1'b1; bus.offset_in = 32'h40;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle noise pc",        bus.pc,          32'h10C);
            chk("idle noise pc_valid",  bus.pc_valid,    0);
            chk("idle noise store_req", bus.store_req,   0);
            chk("idle noise ready",     bus.instr_ready, 1);
        end
        bus.cmp_valid = 1'b0; bus.store_ack = 1'b0;

        // async reset while parked in S_WAIT_CMP
        @(negedge clk);
        bus.instruction = I_BR; bus.offset_in = 32'h8; bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset ready",    bus.instr_ready,  0);
        chk("pre-reset misalign", bus.misalign_err, 1);
        rst = 1'b1;
        #1;
        chk("async reset pc",       bus.pc,          32'h0);
        chk("async reset ready",    bus.instr_ready, 1);
        chk("async reset selects",  {bus.branch_offset, bus.store_offset, bus.jump_offset}, 0);
        chk("async reset store",    {bus.store_req, bus.pc_valid, bus.link_we}, 0);
        chk("async reset addr",     bus.store_addr,  32'h0);
        chk("async reset link",     bus.link_addr,   32'h0);
        chk("async reset misalign", bus.misalign_err, 0);
        @(negedge clk);
        rst = 1'b0;
        exec(17, mk(I_ADD, 32'h0, 32'h0, 0, 0, 0, 32'h4, 3, 1, 0, 32'h0, 0, 3'b000, 0, 32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
